kronos_fetch_unit: RTL

//  Instruction fetch stage: owns the PC, issues word reads on the instruction bus and

---
 rtl/kronos_fetch_unit.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/kronos_fetch_unit.sv
// kronos_fetch_unit
// Instruction fetch stage. Owns the PC, issues word reads on the instruction
// bus and hands {pc, ir} to decode over a valid/ready handshake. An output
// register plus a one-entry skid buffer let a zero-wait memory sustain one
// instruction per cycle. A redirect from EX flushes everything buffered and
// refetches at the branch target, discarding any stale in-flight read.
module kronos_fetch_unit #(
    parameter logic [31:0] BOOT_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rstz,
    output logic [31:0] instr_addr,
    output logic        instr_req,
    input  logic [31:0] instr_data,
    input  logic        instr_ack,
    input  logic        branch,
    input  logic [31:0] branch_target,
    output logic [63:0] fetch,
    output logic        fetch_vld,
    input  logic        fetch_rdy
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        STALL = 2'd1,
        DROP  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } pipeIFID_t;

    // Control state
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic        req_q, req_d;

    // Output register and skid buffer
    pipeIFID_t   out_q, out_d;
    logic        out_vld_q, out_vld_d;
    pipeIFID_t   skid_q, skid_d;
    logic        skid_vld_q, skid_vld_d;

    // Per-cycle events
    logic        consume;
    logic        ack_hit;
    logic        push;
    logic [31:0] target;
    pipeIFID_t   ack_word;

    assign consume  = out_vld_q & fetch_rdy;
    assign ack_hit  = req_q & instr_ack;
    // Only data for a live (non-stale) request may enter the buffers.
    assign push     = ack_hit & (state_q == FETCH);
    // Instructions are word aligned; the low target bits carry no meaning.
    assign target   = branch_target & ~32'h3;
    assign ack_word = '{pc: addr_q, ir: instr_data};

    // Next-state logic: buffering, request sequencing and redirect override
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        req_d      = req_q;
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;

        // A consumed output register is refilled from the skid in the same edge.
        if (consume) begin
            out_d      = skid_q;
            out_vld_d  = skid_vld_q;
            skid_vld_d = 1'b0;
        end

        // New data lands behind anything still buffered, preserving order.
        if (push) begin
            if (!out_vld_d) begin
                out_d     = ack_word;
                out_vld_d = 1'b1;
            end else begin
                skid_d     = ack_word;
                skid_vld_d = 1'b1;
            end
        end

        case (state_q)
            FETCH: begin
                if (ack_hit) begin
                    pc_d = pc_q + 32'd4;
                    if (out_vld_d && skid_vld_d) begin
                        // Both slots occupied: stop requesting until decode drains one.
                        state_d = STALL;
                        req_d   = 1'b0;
                    end else begin
                        req_d  = 1'b1;
                        addr_d = pc_q + 32'd4;
                    end
                end else if (!req_q) begin
                    // Idle in FETCH (just out of reset): start requesting at pc.
                    req_d  = 1'b1;
                    addr_d = pc_q;
                end
            end
            STALL: begin
                if (consume) begin
                    state_d = FETCH;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                end
            end
            DROP: begin
                // Stale read completes; its data is ignored and the target is fetched.
                if (ack_hit) begin
                    state_d = FETCH;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                end
            end
            default: begin
                state_d = FETCH;
                req_d   = 1'b0;
            end
        endcase

        // Redirect wins over ack and consume in the same cycle.
        if (branch) begin
            pc_d       = target;
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
            if (req_q && !instr_ack) begin
                // Bus request cannot be withdrawn: keep it stable and drop its data.
                state_d = DROP;
                req_d   = 1'b1;
                addr_d  = addr_q;
            end else begin
                state_d = FETCH;
                req_d   = 1'b1;
                addr_d  = target;
            end
        end
    end

    // Control and output register update with asynchronous active-low reset
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q    <= FETCH;
            pc_q       <= BOOT_ADDR;
            addr_q     <= BOOT_ADDR;
            req_q      <= 1'b0;
            out_q      <= '0;
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            out_q      <= out_d;
            out_vld_q  <= out_vld_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    // Skid payload is qualified by skid_vld_q and needs no reset
    always_ff @(posedge clk) begin
        skid_q <= skid_d;
    end

    assign instr_addr = addr_q;
    assign instr_req  = req_q;
    assign fetch      = out_q;
    assign fetch_vld  = out_vld_q;

endmodule
